// File: rtl/keypad_poller.sv
// Polling master for the keypad scanner: status/data reads, ack, hex entry.
// Define KEYPAD_POLL_STATS_EN to add the poll_count/empty_polls counters.
module keypad_poller #(
   parameter int POLL_DIV   = 1000,
   parameter int RELEASE_TO = 16
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [15:0] keyin,
   output logic        statusordata,
   output logic        ack,
   output logic [15:0] digits,
   output logic [15:0] value,
   output logic        value_valid,
   output logic        key_valid,
   output logic [7:0]  key_count,
   output logic        err
`ifdef KEYPAD_POLL_STATS_EN
  ,output logic [15:0] poll_count,
   output logic [15:0] empty_polls
`endif
);

   localparam int PW = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int RW = (RELEASE_TO > 1) ? $clog2(RELEASE_TO) : 1;
   localparam logic [PW-1:0] POLL_MAX = PW'(POLL_DIV - 1);
   localparam logic [RW-1:0] REL_MAX  = RW'(RELEASE_TO - 1);

   typedef enum logic [2:0] {
      IDLE,
      STATUS,
      DATA,
      ACK,
      RELEASE
   } state_t;

   state_t        state;
   state_t        next;
   logic [PW-1:0] poll_cnt;
   logic [RW-1:0] rel_cnt;
   logic [3:0]    key;
   logic          timeout;
   logic          ready;

   assign ready = keyin[0];

   always_comb begin
      next    = state;
      timeout = 1'b0;
      unique case (state)
         IDLE:    if (poll_cnt == '0) next = STATUS;
         STATUS:  next = ready ? DATA : IDLE;
         DATA:    next = ACK;
         ACK:     next = RELEASE;
         RELEASE: begin
            if (!ready) begin
               next = IDLE;
            end else if (rel_cnt == REL_MAX) begin
               next    = IDLE;
               timeout = 1'b1;
            end
         end
         default: next = IDLE;
      endcase
   end

   // Moore decode: data word selected only while reading and acking
   assign statusordata = !((state == DATA) || (state == ACK));
   assign ack          = (state == ACK);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         poll_cnt <= POLL_MAX;
         rel_cnt  <= '0;
      end else begin
         state <= next;
         if (state == IDLE) begin
            poll_cnt <= (poll_cnt == '0) ? POLL_MAX : poll_cnt - PW'(1);
         end
         rel_cnt <= (state == RELEASE) ? rel_cnt + RW'(1) : '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         key         <= '0;
         digits      <= '0;
         value       <= '0;
         value_valid <= 1'b0;
         key_valid   <= 1'b0;
         key_count   <= '0;
         err         <= 1'b0;
      end else begin
         key_valid   <= (state == ACK);
         value_valid <= (state == ACK) && (key == 4'hF);
         err         <= err | timeout;
         if (state == DATA) key <= keyin[3:0];
         if (state == ACK) begin
            key_count <= key_count + 8'd1;
            unique case (1'b1)
               (key == 4'hE): digits <= '0;
               (key == 4'hF): begin
                  value  <= digits;
                  digits <= '0;
               end
               default: digits <= {digits[11:0], key};
            endcase
         end
      end
   end

`ifdef KEYPAD_POLL_STATS_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         poll_count  <= '0;
         empty_polls <= '0;
      end else if (state == STATUS) begin
         if (poll_count != 16'hFFFF) poll_count <= poll_count + 16'd1;
         if (!ready && empty_polls != 16'hFFFF) begin
            empty_polls <= empty_polls + 16'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_keypad_poller.sv
// Randomised scoreboard bench for keypad_poller with a scanner model
// and a hex-entry reference model.
module tb_keypad_poller;

   localparam int POLL_DIV   = 4;
   localparam int RELEASE_TO = 16;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic [15:0] keyin;
   logic        statusordata;
   logic        ack;
   logic [15:0] digits;
   logic [15:0] value;
   logic        value_valid;
   logic        key_valid;
   logic [7:0]  key_count;
   logic        err;
`ifdef KEYPAD_POLL_STATS_EN
   logic [15:0] poll_count;
   logic [15:0] empty_polls;
`endif

   logic        ready = 1'b0;
   logic [3:0]  cur_key = 4'h0;
   logic [15:0] noise = 16'h0;

   int checks = 0;
   int errors = 0;

   typedef struct {
      logic [15:0] digits;
      logic [15:0] value;
      logic [7:0]  count;
      logic        vv;
   } exp_t;

   exp_t sbq[$];
   int   m_digits = 0;
   int   m_value  = 0;
   int   m_count  = 0;

   keypad_poller #(
      .POLL_DIV   (POLL_DIV),
      .RELEASE_TO (RELEASE_TO)
   ) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .keyin        (keyin),
      .statusordata (statusordata),
      .ack          (ack),
      .digits       (digits),
      .value        (value),
      .value_valid  (value_valid),
      .key_valid    (key_valid),
      .key_count    (key_count),
      .err          (err)
`ifdef KEYPAD_POLL_STATS_EN
     ,.poll_count   (poll_count),
      .empty_polls  (empty_polls)
`endif
   );

   always #5 clk = ~clk;

   // Scanner: unused bits carry random noise the poller must ignore
   assign keyin = statusordata ? {noise[15:1], ready}
                               : {noise[15:4], cur_key};

   initial forever begin
      @(negedge clk);
      noise = 16'($urandom);
   end

   task automatic check(input string name, input logic [15:0] act,
                        input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic model_key(input int k);
      exp_t e;
      m_count = (m_count + 1) % 256;
      e.vv = 1'b0;
      if (k == 14) begin
         m_digits = 0;
      end else if (k == 15) begin
         m_value  = m_digits;
         m_digits = 0;
         e.vv     = 1'b1;
      end else begin
         m_digits = (m_digits * 16 + k) % 65536;
      end
      e.digits = m_digits[15:0];
      e.value  = m_value[15:0];
      e.count  = m_count[7:0];
      sbq.push_back(e);
   endtask

   task automatic wait_ack(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ack) begin
            ok = 1'b1;
            break;
         end
      end
      check("ack_seen", {15'd0, ok}, 16'd1);
      if (ok) check("ack_needs_ready", {15'd0, ready}, 16'd1);
   endtask

   task automatic drop_ready();
      repeat ($urandom_range(0, 3)) @(negedge clk);
      ready = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic send_key(input int k);
      bit ok;
      cur_key = k[3:0];
      ready   = 1'b1;
      wait_ack(ok);
      if (ok) model_key(k);
      drop_ready();
   endtask

   task automatic drain();
      int n = 0;
      while (sbq.size() != 0 && n < 50) begin
         @(negedge clk);
         n++;
      end
      check("drain", 16'(sbq.size()), 16'd0);
      @(negedge clk);
   endtask

   // Monitor: pops the scoreboard on every key_valid pulse
   initial begin
      bit   prev_ack = 1'b0;
      exp_t e;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            prev_ack = 1'b0;
         end else begin
            if (ack) check("no_back_to_back_ack", {15'd0, prev_ack}, 16'd0);
            prev_ack = ack;
            if (value_valid && !key_valid) begin
               check("value_valid_alone", {15'd0, value_valid}, 16'd0);
            end
            if (key_valid) begin
               if (sbq.size() == 0) begin
                  check("unexpected_key_valid", {15'd0, key_valid}, 16'd0);
               end else begin
                  e = sbq.pop_front();
                  check("digits", digits, e.digits);
                  check("value", value, e.value);
                  check("key_count", {8'd0, key_count}, {8'd0, e.count});
                  check("value_valid", {15'd0, value_valid}, {15'd0, e.vv});
               end
            end
         end
      end
   end

   initial begin
      bit ok;
      int k;
      #2 rst_n = 1'b0;
      repeat (3) @(negedge clk);
      rst_n = 1'b1;

      repeat (25) begin
         @(negedge clk);
         check("idle_statusordata", {15'd0, statusordata}, 16'd1);
         check("idle_ack", {15'd0, ack}, 16'd0);
         check("idle_outputs", digits | value | {8'd0, key_count} |
               {13'd0, err, key_valid, value_valid}, 16'd0);
      end

      send_key(7);
      drain();
      check("first_key_digits", digits, 16'h0007);
      check("first_key_count", {8'd0, key_count}, 16'd1);

      for (int i = 1; i <= 5; i++) send_key(i);
      drain();
      check("entry_2345", digits, 16'h2345);
      send_key(15);
      drain();
      check("commit_value", value, 16'h2345);
      check("commit_clears", digits, 16'h0000);

      send_key(9);
      send_key(10);
      send_key(14);
      drain();
      check("clear_digits", digits, 16'h0000);
      check("clear_keeps_value", value, 16'h2345);
      check("clear_count", {8'd0, key_count}, 16'(m_count));

      repeat (40) send_key($urandom_range(0, 15));
      drain();

      // Scanner ignores ack: release timeout, then the same key is re-read
      k       = $urandom_range(0, 13);
      cur_key = k[3:0];
      ready   = 1'b1;
      wait_ack(ok);
      if (ok) model_key(k);
      repeat (RELEASE_TO) @(negedge clk);
      check("err_before_timeout", {15'd0, err}, 16'd0);
      @(negedge clk);
      check("err_after_timeout", {15'd0, err}, 16'd1);
      wait_ack(ok);
      if (ok) model_key(k);
      drop_ready();
      drain();
      check("err_sticky", {15'd0, err}, 16'd1);

      rst_n = 1'b0;
      #1;
      check("err_reset", {15'd0, err}, 16'd0);
      @(negedge clk);
      rst_n    = 1'b1;
      m_digits = 0;
      m_value  = 0;
      m_count  = 0;

      // Reset during ACK: pending key must arrive on the first new poll
      k       = $urandom_range(0, 13);
      cur_key = k[3:0];
      ready   = 1'b1;
      wait_ack(ok);
      #1 rst_n = 1'b0;
      #1;
      check("rst_ack_low", {15'd0, ack}, 16'd0);
      check("rst_statusordata", {15'd0, statusordata}, 16'd1);
      check("rst_outputs", digits | value | {8'd0, key_count} |
            {13'd0, err, key_valid, value_valid}, 16'd0);
      @(negedge clk);
      rst_n = 1'b1;
      wait_ack(ok);
      if (ok) model_key(k);
      drop_ready();
      drain();
      check("post_reset_count", {8'd0, key_count}, 16'd1);
      check("post_reset_digits", digits, 16'(k));

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
